// File: rtl/piso_shift_tx.sv
// piso_shift_tx: accepts a word over valid/ready and shifts it out one bit per shift_en tick.
// Back-to-back words are accepted on the edge that consumes the last bit of the previous one.
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             busy,
    output logic             done
);
    localparam int   CW    = $clog2(WIDTH);
    localparam logic IDLE  = 1'b0;
    localparam logic SHIFT = 1'b1;

    logic             state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] nxt;
    logic             last;
    logic             accept;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    always_comb begin
        last       = (state == SHIFT) && shift_en && (count == '0);
        load_ready = (state == IDLE) || last;
        accept     = load_valid && load_ready;
        nxt        = MSB_FIRST ? shreg << 1 : shreg >> 1;
        busy       = state == SHIFT;
        sdo_valid  = state == SHIFT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            count <= '0;
            sdo   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                state <= SHIFT;
                shreg <= load_data;
                count <= CW'(WIDTH - 1);
                sdo   <= first_bit(load_data);
            end else if (last) begin
                state <= IDLE;
                sdo   <= 1'b0;
            end else if (state == SHIFT && shift_en) begin
                shreg <= nxt;
                sdo   <= first_bit(nxt);
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
Parallel-in serial-out shift transmitter. Accepts a WIDTH-bit word over a valid/ready load handshake and drives it out one bit per enabled clock on a single serial line. It is the transmit end that feeds the team's serial-in shift register chain. Internal state is an FSM, a bit counter and a shift register.

Parameters:
WIDTH, 8, word length in bits; legal values are WIDTH >= 2.
MSB_FIRST, 0, bit order: 0 sends bit 0 first, 1 sends bit WIDTH-1 first.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  asynchronous active-low reset; 0 resets immediately.
load_valid  input  1  load_data is offered.
load_ready  output  1  the block can accept a word this cycle.
load_data  input  WIDTH  parallel word; sampled only on a handshake.
shift_en  input  1  bit-advance enable, a tick from the downstream shift register.
sdo  output  1  serial data out (registered).
sdo_valid  output  1  sdo carries a payload bit.
busy  output  1  a word is in flight (state SHIFT).
done  output  1  one-cycle pulse after the last bit of a word is consumed.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state=IDLE, shreg=0, count=0
  - sdo=0, sdo_valid=0, busy=0, done=0
  - load_ready=1, combinational from state
- Reset mid-word aborts the word, with no done pulse. After rst returns to 1, the block restarts in IDLE.
- Handshake: a word is accepted at a rising edge where load_valid=1 and load_ready=1. load_valid while load_ready=0 is ignored; the block holds nothing.
- load_ready is combinational: (state==IDLE) OR (state==SHIFT AND count==0 AND shift_en==1).
  - This permits back-to-back words with no idle bit.
  - load_ready depends on shift_en combinationally. The source must not make load_valid depend on load_ready.
- States: IDLE and SHIFT.
- IDLE:
  - sdo=0, sdo_valid=0, busy=0.
  - shift_en is ignored.
  - On accept: shreg<=load_data, count<=WIDTH-1, state<=SHIFT.
  - The first bit appears on sdo in the cycle after accept, with sdo_valid=1 and busy=1. Latency is 1 clock.
- SHIFT with shift_en=0: all state and outputs hold (stall), for any duration.
- SHIFT with shift_en=1 and count>0: shreg shifts toward the next bit in the selected order, sdo<=next bit, count<=count-1.
- SHIFT with shift_en=1 and count==0 (last bit consumed):
  - done<=1 for exactly one cycle.
  - If a new word is accepted on the same edge, the first bit of the new word goes to sdo, count<=WIDTH-1, and the block stays in SHIFT. sdo_valid stays 1 and busy stays 1.
  - Otherwise the block goes to IDLE with sdo<=0 and sdo_valid<=0.
- Timing: with shift_en held at 1, a word occupies sdo for exactly WIDTH cycles.
- count width is clog2(WIDTH). No arithmetic beyond a decrement; count never wraps, because the decrement is gated by count>0.
- done is deasserted in every other cycle.
- Unknown (X) inputs are not propagated into state while rst=0.

Test Plan:
1. Reset. Assert rst=0 mid-simulation at a non-clock time -> immediately sdo=0, sdo_valid=0, busy=0, done=0, load_ready=1.
2. LSB-first word. WIDTH=8, MSB_FIRST=0, load 0x1E, shift_en=1 continuously -> first bit 1 cycle after accept; sdo sequence 0,1,1,1,1,0,0,0 over 8 cycles with sdo_valid=1; done=1 on the following cycle; sdo_valid=0 afterwards.
3. MSB-first word. MSB_FIRST=1, load 0x1E -> sdo sequence 0,0,0,1,1,1,1,0.
4. Stalls and ignored loads. Load 0xA5 (LSB first), drop shift_en for 3 cycles after the second bit, and raise load_valid with 0xFF during the word -> sdo holds bit 1 (=0) during the stall; load_ready=0 and 0xFF is never sent; full sequence 1,0,1,0,0,1,0,1.
5. Back-to-back words. Hold load_valid=1 with 0x0F then 0xF0 (LSB first), shift_en=1 -> 16 contiguous bits 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1; sdo_valid never drops between words; done pulses twice, 8 cycles apart.
6. Reset mid-word. Assert rst=0 after 3 bits of 0x1E -> immediate return to reset values and no done pulse; a fresh load of 0x01 then sends 1,0,0,0,0,0,0,0.
